// File: rtl/rc5_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : rc5_encrypt_core
// Description : RC5-W/R/b block encryption engine. After the key mixer has
//               filled the shared S RAM (iKeyReady=1), each accepted iStart
//               encrypts one 2W-bit block. S[0..T-1] is fetched one word at
//               a time through a single synchronous-read RAM port. Each word
//               costs two cycles: one to present the address, one to consume
//               the data.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active low
//               iStart     - start request (level, sampled in IDLE)
//               iKeyReady  - S table valid
//               iPlainA/B  - plaintext words, latched on accepted start
//               oS_address - registered S RAM read address
//               iS_sub_i   - S RAM read data (one cycle after address)
//               oCipherA/B - ciphertext, valid from oDone until next start
//               oBusy      - high from start acceptance through oDone cycle
//               oDone      - one-cycle pulse when ciphertext is valid
// Revision    : 1.0 - initial release
// ============================================================================
module rc5_encrypt_core #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int T = 2 * R + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    input  logic                 iKeyReady,
    input  logic [W-1:0]         iPlainA,
    input  logic [W-1:0]         iPlainB,
    output logic [$clog2(T)-1:0] oS_address,
    input  logic [W-1:0]         iS_sub_i,
    output logic [W-1:0]         oCipherA,
    output logic [W-1:0]         oCipherB,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int c_AW   = $clog2(T);
    localparam int c_LOGW = $clog2(W);

    localparam logic [c_AW-1:0] c_LAST_K = c_AW'(T - 1);
    localparam logic [c_AW-1:0] c_K_ONE  = c_AW'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD_ADDR = 2'd1;
    localparam logic [1:0] c_ST_RD_DATA = 2'd2;
    localparam logic [1:0] c_ST_FINISH  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_nextState;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    w_nextA;
    logic [W-1:0]    w_nextB;
    logic [W-1:0]    w_rotAB;
    logic [W-1:0]    w_rotBA;
    logic [c_AW-1:0] r_k;
    logic [c_AW-1:0] r_sAddr;
    logic [W-1:0]    r_cipherA;
    logic [W-1:0]    r_cipherB;
    logic            w_accept;
    logic            w_lastWord;

    // Left rotate by the low log2(W) bits; the upper half of the shifted
    // doubled word is exactly the rotated value.
    function automatic logic [W-1:0] f_rotl(input logic [W-1:0] v,
                                            input logic [c_LOGW-1:0] s);
        logic [2*W-1:0] t;
        t = {v, v} << s;
        return t[2*W-1:W];
    endfunction

    assign w_accept   = (r_state == c_ST_IDLE) && iStart && iKeyReady;
    assign w_lastWord = (r_k == c_LAST_K);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_accept) w_nextState = c_ST_RD_ADDR;
            c_ST_RD_ADDR: w_nextState = c_ST_RD_DATA;
            c_ST_RD_DATA: w_nextState = w_lastWord ? c_ST_FINISH : c_ST_RD_ADDR;
            c_ST_FINISH:  w_nextState = c_ST_IDLE;
            default:      w_nextState = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: busy covers every non-idle state, which includes the
    // FINISH cycle where oDone is high.
    // ------------------------------------------------------------------
    always_comb begin
        oBusy      = (r_state != c_ST_IDLE);
        oDone      = (r_state == c_ST_FINISH);
        oS_address = r_sAddr;
        oCipherA   = r_cipherA;
        oCipherB   = r_cipherB;
    end

    // ------------------------------------------------------------------
    // Round arithmetic for the S word currently on iS_sub_i. Odd steps use
    // the A already updated by the preceding even step, which is simply r_a.
    // ------------------------------------------------------------------
    assign w_rotAB = f_rotl(r_a ^ r_b, r_b[c_LOGW-1:0]);
    assign w_rotBA = f_rotl(r_b ^ r_a, r_a[c_LOGW-1:0]);

    always_comb begin
        w_nextA = r_a;
        w_nextB = r_b;
        if (r_k == '0) begin
            w_nextA = r_a + iS_sub_i;
        end else if (r_k == c_K_ONE) begin
            w_nextB = r_b + iS_sub_i;
        end else if (!r_k[0]) begin
            w_nextA = w_rotAB + iS_sub_i;
        end else begin
            w_nextB = w_rotBA + iS_sub_i;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_sAddr   <= '0;
            r_cipherA <= '0;
            r_cipherB <= '0;
        end else if (w_accept) begin
            r_a     <= iPlainA;
            r_b     <= iPlainB;
            r_k     <= '0;
            r_sAddr <= '0;
        end else if (r_state == c_ST_RD_DATA) begin
            r_a <= w_nextA;
            r_b <= w_nextB;
            if (w_lastWord) begin
                r_cipherA <= w_nextA;
                r_cipherB <= w_nextB;
            end else begin
                r_k     <= r_k + c_K_ONE;
                r_sAddr <= r_sAddr + c_K_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc5_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc5_encrypt_core
// Description : Self-checking bench for rc5_encrypt_core. Holds a model of the
//               S RAM, builds the zero-key RC5-32/12/16 S table and compares
//               every ciphertext against a word-level RC5 reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc5_encrypt_core;

    localparam int W  = 32;
    localparam int R  = 12;
    localparam int T  = 26;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          iStart = 1'b0;
    logic          iKeyReady = 1'b0;
    logic [W-1:0]  iPlainA = '0;
    logic [W-1:0]  iPlainB = '0;
    logic [AW-1:0] oS_address;
    logic [W-1:0]  sData;
    logic [W-1:0]  oCipherA;
    logic [W-1:0]  oCipherB;
    logic          oBusy;
    logic          oDone;

    logic [W-1:0]  sMem [T];
    logic [AW-1:0] addrQ [$];
    logic [63:0]   pendQ [$];

    int checks   = 0;
    int failures = 0;

    rc5_encrypt_core #(.W(W), .R(R), .T(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iKeyReady  (iKeyReady),
        .iPlainA    (iPlainA),
        .iPlainB    (iPlainB),
        .oS_address (oS_address),
        .iS_sub_i   (sData),
        .oCipherA   (oCipherA),
        .oCipherB   (oCipherB),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: address sampled at the edge, data valid after it.
    always @(posedge clk) sData <= sMem[oS_address];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        int n;
        n = s & 31;
        if (n == 0) return v;
        return (v << n) | (v >> (32 - n));
    endfunction

    // RC5 encryption as written in the algorithm description.
    function automatic logic [63:0] rc5Ref(input logic [31:0] pa, input logic [31:0] pb);
        logic [31:0] a, b;
        a = pa + sMem[0];
        b = pb + sMem[1];
        for (int i = 1; i <= R; i++) begin
            a = rotl(a ^ b, int'(b[4:0])) + sMem[2*i];
            b = rotl(b ^ a, int'(a[4:0])) + sMem[2*i+1];
        end
        return {a, b};
    endfunction

    // RC5-32/12/16 key expansion for an all-zero 16-byte key.
    task automatic buildZeroKeyTable();
        logic [31:0] L [4];
        logic [31:0] a, b;
        int i, j;
        sMem[0] = 32'hB7E15163;
        for (int n = 1; n < T; n++) sMem[n] = sMem[n-1] + 32'h9E3779B9;
        for (int n = 0; n < 4; n++) L[n] = '0;
        a = '0; b = '0; i = 0; j = 0;
        for (int n = 0; n < 3 * T; n++) begin
            sMem[i] = rotl(sMem[i] + a + b, 3);
            a = sMem[i];
            L[j] = rotl(L[j] + a + b, int'((a + b) & 32'd31));
            b = L[j];
            i = (i + 1) % T;
            j = (j + 1) % 4;
        end
    endtask

    // Presents a start for exactly one edge; returns at the negedge after it.
    task automatic startBlock(input logic [31:0] pa, input logic [31:0] pb);
        @(negedge clk);
        iPlainA = pa; iPlainB = pb; iStart = 1'b1; iKeyReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iStart = 1'b0;
        addrQ.delete();
        addrQ.push_back(oS_address);
    endtask

    // Counts edges after acceptance until oDone; optionally re-pulses iStart.
    task automatic waitDone(input int pulseAt, output int lat);
        lat = -1;
        for (int m = 1; m <= 200; m++) begin
            @(negedge clk);
            addrQ.push_back(oS_address);
            if (m == pulseAt) begin
                iStart = 1'b1; iPlainA = $urandom; iPlainB = $urandom;
            end else begin
                iStart = 1'b0;
            end
            if (oDone) begin
                lat = m;
                break;
            end
        end
        iStart = 1'b0;
        if (lat < 0) checkVal("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int lat, bad, dones, cyc, lastDone, lowRun;
        logic [31:0] pa, pb, curA, curB;
        logic [AW-1:0] holdAddr;
        logic prevBusy;
        logic [63:0] exp;

        for (int n = 0; n < T; n++) sMem[n] = '0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_busy", oBusy, 0);
        checkVal("rst_done", oDone, 0);
        checkVal("rst_addr", oS_address, 0);
        checkVal("rst_cipher", {oCipherA, oCipherB}, 0);
        rst = 1'b1;

        // Zero S table, zero plaintext
        startBlock(32'h0, 32'h0);
        checkVal("t1_busy_on_accept", oBusy, 1);
        waitDone(-1, lat);
        checkVal("t1_latency", lat, 52);
        checkVal("t1_cipher", {oCipherA, oCipherB}, 64'h0);
        @(negedge clk);
        checkVal("t1_done_one_cycle", oDone, 0);
        checkVal("t1_busy_after", oBusy, 0);

        // Zero-key S table, known-answer vector
        buildZeroKeyTable();
        startBlock(32'h0, 32'h0);
        waitDone(-1, lat);
        checkVal("t2_latency", lat, 52);
        checkVal("t2_known_answer", {oCipherA, oCipherB}, 64'hEEDBA521_6D8F4B15);
        checkVal("t2_model", {oCipherA, oCipherB}, rc5Ref(32'h0, 32'h0));
        checkVal("t2_addr_len", addrQ.size(), 53);
        bad = 0;
        foreach (addrQ[m]) if (addrQ[m] != AW'((m / 2 > 25) ? 25 : m / 2)) bad++;
        checkVal("t2_addr_seq", bad, 0);

        // Start without key ready is ignored
        @(negedge clk);
        holdAddr = oS_address;
        iKeyReady = 1'b0; iStart = 1'b1; iPlainA = $urandom; iPlainB = $urandom;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (oBusy !== 1'b0 || oDone !== 1'b0 || oS_address !== holdAddr) bad++;
        end
        checkVal("t3_ignored_no_key", bad, 0);
        pa = $urandom; pb = $urandom;
        iPlainA = pa; iPlainB = pb; iKeyReady = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        checkVal("t3_accept_busy", oBusy, 1);
        checkVal("t3_accept_addr", oS_address, 0);
        waitDone(-1, lat);
        checkVal("t3_latency", lat, 52);
        checkVal("t3_cipher", {oCipherA, oCipherB}, rc5Ref(pa, pb));

        // Second start mid-block is ignored
        pa = $urandom; pb = $urandom;
        startBlock(pa, pb);
        waitDone(10, lat);
        checkVal("t4_latency", lat, 52);
        checkVal("t4_cipher", {oCipherA, oCipherB}, rc5Ref(pa, pb));
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (oDone) bad++;
        end
        checkVal("t4_extra_done", bad, 0);

        // Reset mid-operation
        startBlock($urandom, $urandom);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkVal("t5_busy", oBusy, 0);
        checkVal("t5_done", oDone, 0);
        checkVal("t5_addr", oS_address, 0);
        checkVal("t5_cipher", {oCipherA, oCipherB}, 0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (oBusy || oDone) bad++;
        end
        checkVal("t5_stays_idle", bad, 0);
        pa = $urandom; pb = $urandom;
        startBlock(pa, pb);
        waitDone(-1, lat);
        checkVal("t5_restart_cipher", {oCipherA, oCipherB}, rc5Ref(pa, pb));

        // Back-to-back blocks with iStart held high
        repeat (3) @(negedge clk);
        curA = $urandom; curB = $urandom;
        iPlainA = curA; iPlainB = curB; iKeyReady = 1'b1; iStart = 1'b1;
        prevBusy = oBusy;
        dones = 0; lastDone = -1; lowRun = 0; pendQ.delete();
        for (cyc = 0; cyc < 6000 && dones < 100; cyc++) begin
            @(negedge clk);
            if (!oBusy) lowRun++;
            if (oBusy && !prevBusy) begin
                if (dones > 0) checkVal("t6_busy_low_cycles", lowRun, 1);
                lowRun = 0;
                pendQ.push_back({curA, curB});
            end
            if (oDone) begin
                if (pendQ.size() == 0) begin
                    checkVal("t6_unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp = pendQ.pop_front();
                    checkVal("t6_cipher", {oCipherA, oCipherB}, rc5Ref(exp[63:32], exp[31:0]));
                end
                if (lastDone >= 0) checkVal("t6_done_period", cyc - lastDone, 54);
                lastDone = cyc;
                dones++;
            end
            prevBusy = oBusy;
            curA = $urandom; curB = $urandom;
            iPlainA = curA; iPlainB = curB;
        end
        iStart = 1'b0;
        checkVal("t6_done_count", dones, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
